// File: rtl/podule_cycle_decode.sv
// Podule bus cycle decoder: turns a four-phase host request into a timed
// ROM / I/O-region select strobe followed by a registered acknowledge.
module podule_cycle_decode #(
  parameter int                N_CS    = 7,
  parameter logic [N_CS*4-1:0] WS      = '0,
  parameter int unsigned       ROM_WS  = 2,
  parameter int                PAGE_W  = 8,
  parameter int                FPL_IDX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [13:2]       a,
  input  logic              cyc,
  input  logic              we,
  input  logic [PAGE_W-1:0] wdata,
  output logic              ack,
  output logic              rom_cs,
  output logic [N_CS-1:0]   cs,
  output logic [PAGE_W-1:0] rom_page,
  output logic              busy
);

  localparam logic [3:0] ROM_N = 4'(ROM_WS);
  localparam logic [2:0] FPL_3 = 3'(FPL_IDX);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                drop_q, drop_d;
  logic                first_q, first_d;
  logic                ack_q, ack_d;
  logic                rom_cs_q, rom_cs_d;
  logic [N_CS-1:0]     cs_q, cs_d;
  logic [PAGE_W-1:0]   page_q, page_d;

  // Request fields captured once per cycle; only a[13:10] matter for decode.
  logic [3:0]          hi_q;
  logic                we_q;
  logic [PAGE_W-1:0]   wdata_q;

  logic                is_rom;
  logic [2:0]          idx;
  logic                mapped;
  logic [3:0]          n_sel;
  logic [N_CS-1:0]     onehot;

  // Word-offset address bits do not take part in the decode.
  logic                unused_addr;
  assign unused_addr = ^a[9:2];

  // Decode the latched address into target, one-hot select and wait count.
  always_comb begin
    is_rom = ~hi_q[3];
    idx    = hi_q[2:0];
    mapped = is_rom;
    n_sel  = ROM_N;
    onehot = '0;
    for (int k = 0; k < N_CS; k++) begin
      if (!is_rom && idx == 3'(k)) begin
        mapped    = 1'b1;
        n_sel     = WS[4*k +: 4];
        onehot[k] = 1'b1;
      end
    end
  end

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (cyc) state_d = SETUP;
      end
      SETUP: begin
        if (mapped) begin
          state_d = STROBE;
          cnt_d   = n_sel;
        end else begin
          state_d = DONE;
        end
      end
      STROBE: begin
        if (cnt_q == 4'd0) state_d = HOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      HOLD:    state_d = DONE;
      DONE:    if (!cyc || drop_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A host that lets go early forfeits the acknowledge for this cycle.
    if (state_q != IDLE && !cyc) drop_d = 1'b1;

    first_d  = (state_q == SETUP) && (state_d == STROBE);
    ack_d    = (state_d == DONE) && cyc && !drop_q;
    rom_cs_d = (state_d == STROBE) && is_rom;
    cs_d     = (state_d == STROBE) ? onehot : '0;

    page_d = page_q;
    if (state_q == STROBE && first_q && we_q && !is_rom && idx == FPL_3)
      page_d = wdata_q;
  end

  // Capture the request when a new cycle is accepted.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && cyc) begin
      hi_q    <= a[13:10];
      we_q    <= we;
      wdata_q <= wdata;
    end
  end

  // Control state and glitch-free output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
      first_q  <= 1'b0;
      ack_q    <= 1'b0;
      rom_cs_q <= 1'b0;
      cs_q     <= '0;
      page_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      first_q  <= first_d;
      ack_q    <= ack_d;
      rom_cs_q <= rom_cs_d;
      cs_q     <= cs_d;
      page_q   <= page_d;
    end
  end

  assign ack      = ack_q;
  assign rom_cs   = rom_cs_q;
  assign cs       = cs_q;
  assign rom_page = page_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_podule_cycle_decode.sv
// Directed bench for podule_cycle_decode: one 7-region instance with wait
// states on regions 1 and 4, one 5-region instance with default timing.
module tb_podule_cycle_decode;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, cyc1, we1, ack1, romcs1, busy1;
  logic [13:0] ad1;
  logic [7:0]  wd1, page1;
  logic [6:0]  cs1;

  logic        rst2, cyc2, we2, ack2, romcs2, busy2;
  logic [13:0] ad2;
  logic [7:0]  wd2, page2;
  logic [4:0]  cs2;

  int total = 0;
  int bad   = 0;
  logic ackseen;

  podule_cycle_decode #(.N_CS(7), .WS(28'h0020030)) u1 (
    .clk(clk), .rst(rst1), .a(ad1[13:2]), .cyc(cyc1), .we(we1), .wdata(wd1),
    .ack(ack1), .rom_cs(romcs1), .cs(cs1), .rom_page(page1), .busy(busy1)
  );

  podule_cycle_decode #(.N_CS(5)) u2 (
    .clk(clk), .rst(rst2), .a(ad2[13:2]), .cyc(cyc2), .we(we2), .wdata(wd2),
    .ack(ack2), .rom_cs(romcs2), .cs(cs2), .rom_page(page2), .busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst1 = 1'b1; cyc1 = 1'b0; we1 = 1'b0; ad1 = '0; wd1 = '0;
    rst2 = 1'b1; cyc2 = 1'b0; we2 = 1'b0; ad2 = '0; wd2 = '0;
    tick(); tick();
    chk("rst_ack", ack1, 0);
    chk("rst_romcs", romcs1, 0);
    chk("rst_cs", cs1, 0);
    chk("rst_page", page1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_busy2", busy2, 0);
    rst1 = 1'b0; rst2 = 1'b0;
    tick();

    // ROM read, ROM_WS=2: rom_cs cycles 2..4, ack cycle 6
    ad1 = 14'h0100; cyc1 = 1'b1;
    tick();
    chk("rom_c1_busy", busy1, 1);
    chk("rom_c1_sel", romcs1, 0);
    ad1 = 14'h2400;
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk("rom_strobe", romcs1, 1);
      chk("rom_strobe_cs", cs1, 0);
      chk("rom_strobe_ack", ack1, 0);
    end
    tick();
    chk("rom_hold_sel", romcs1, 0);
    chk("rom_hold_busy", busy1, 1);
    chk("rom_hold_ack", ack1, 0);
    tick();
    chk("rom_ack_c6", ack1, 1);
    chk("rom_busy_c6", busy1, 1);
    tick();
    chk("rom_ack_held", ack1, 1);
    cyc1 = 1'b0;
    tick();
    chk("rom_ack_fall", ack1, 0);
    chk("rom_idle", busy1, 0);

    // I/O region 1, WS=3: cs=0000010 cycles 2..5, ack cycle 7
    ad1 = 14'h2400; cyc1 = 1'b1;
    tick();
    chk("io1_c1_cs", cs1, 0);
    for (int c = 2; c <= 5; c++) begin
      tick();
      chk("io1_strobe", cs1, 7'b0000010);
      chk("io1_strobe_rom", romcs1, 0);
    end
    tick();
    chk("io1_hold_cs", cs1, 0);
    chk("io1_hold_ack", ack1, 0);
    tick();
    chk("io1_ack_c7", ack1, 1);
    cyc1 = 1'b0;
    tick();
    chk("io1_ack_fall", ack1, 0);

    // Write to region 4 loads the page register after the first strobe cycle
    ad1 = 14'h3000; we1 = 1'b1; wd1 = 8'hA5; cyc1 = 1'b1;
    tick();
    tick();
    chk("fpl_c2_cs", cs1, 7'h10);
    chk("fpl_c2_page", page1, 8'h00);
    tick();
    chk("fpl_c3_page", page1, 8'hA5);
    chk("fpl_c3_cs", cs1, 7'h10);
    tick();
    chk("fpl_c4_cs", cs1, 7'h10);
    tick();
    chk("fpl_hold_cs", cs1, 0);
    tick();
    chk("fpl_ack", ack1, 1);
    cyc1 = 1'b0; we1 = 1'b0;
    tick();

    // Read of region 4 must not touch the page register
    ad1 = 14'h3000; wd1 = 8'h3C; cyc1 = 1'b1;
    repeat (6) tick();
    chk("fpl_rd_ack", ack1, 1);
    chk("fpl_rd_page", page1, 8'hA5);
    cyc1 = 1'b0;
    tick();

    // Reset on the second strobe cycle, with cyc still high
    ad1 = 14'h3000; we1 = 1'b1; wd1 = 8'h5A; cyc1 = 1'b1;
    tick();
    tick();
    chk("rstm_c2_page", page1, 8'hA5);
    tick();
    chk("rstm_c3_page", page1, 8'h5A);
    chk("rstm_c3_cs", cs1, 7'h10);
    rst1 = 1'b1;
    tick();
    chk("rstm_cs", cs1, 0);
    chk("rstm_ack", ack1, 0);
    chk("rstm_page", page1, 0);
    chk("rstm_busy", busy1, 0);
    chk("rstm_romcs", romcs1, 0);
    rst1 = 1'b0; cyc1 = 1'b0; we1 = 1'b0;
    tick();
    chk("rstm_after_busy", busy1, 0);
    chk("rstm_after_ack", ack1, 0);

    // cyc dropped during SETUP: full strobe, no ack, back to IDLE after DONE
    ad1 = 14'h0100; cyc1 = 1'b1;
    tick();
    cyc1 = 1'b0;
    ackseen = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk("drop_strobe", romcs1, 1);
      ackseen = ackseen | ack1;
    end
    tick();
    chk("drop_hold_sel", romcs1, 0);
    chk("drop_hold_busy", busy1, 1);
    ackseen = ackseen | ack1;
    tick();
    chk("drop_done_busy", busy1, 1);
    ackseen = ackseen | ack1;
    tick();
    chk("drop_idle", busy1, 0);
    ackseen = ackseen | ack1;
    chk("drop_no_ack", ackseen, 0);

    // N_CS=5: region 6 unmapped, ack 2 cycles after cyc, no selects
    ad2 = 14'h3800; cyc2 = 1'b1;
    tick();
    chk("unm_c1_busy", busy2, 1);
    chk("unm_c1_cs", cs2, 0);
    chk("unm_c1_ack", ack2, 0);
    tick();
    chk("unm_ack", ack2, 1);
    chk("unm_cs", cs2, 0);
    chk("unm_romcs", romcs2, 0);
    cyc2 = 1'b0;
    tick();
    chk("unm_ack_fall", ack2, 0);
    chk("unm_idle", busy2, 0);

    // N_CS=5: highest mapped region 4, no wait states
    ad2 = 14'h3000; cyc2 = 1'b1;
    tick();
    tick();
    chk("top_cs", cs2, 5'h10);
    tick();
    chk("top_hold_cs", cs2, 0);
    tick();
    chk("top_ack", ack2, 1);
    chk("top_page", page2, 0);
    cyc2 = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/podule_cycle_decode.md
PODULE_CYCLE_DECODE -- requirements
Module: podule_cycle_decode

Interface
REQ-001 SHALL have parameter N_CS, default 7: number of external I/O selects, range 1..7.
REQ-002 SHALL have parameter WS, default 0 (packed N_CS x 4 bits): extra strobe cycles per I/O region; region k uses WS[4k+3:4k].
REQ-003 SHALL have parameter ROM_WS, default 2: extra strobe cycles for the ROM window.
REQ-004 SHALL have parameter PAGE_W, default 8: width of the ROM page register.
REQ-005 SHALL have parameter FPL_IDX, default 4: region index that also writes the ROM page register.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port a, input, bits [13:2]: host word address.
REQ-009 SHALL have port cyc, input, 1 bit: host cycle request, level, four-phase.
REQ-010 SHALL have port we, input, 1 bit: write qualifier, sampled with a.
REQ-011 SHALL have port wdata, input, PAGE_W bits: page-register write data, sampled with a.
REQ-012 SHALL have port ack, output, 1 bit: cycle-complete acknowledge.
REQ-013 SHALL have port rom_cs, output, 1 bit: ROM window select.
REQ-014 SHALL have port cs, output, N_CS bits: one-hot I/O region selects.
REQ-015 SHALL have port rom_page, output, PAGE_W bits: current ROM page register.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 SHALL decode the latched address as: a[13]=0 -> ROM; a[13]=1 -> region idx=a[12:10]; idx>=N_CS -> unmapped.
REQ-018 SHALL implement states IDLE, SETUP, STROBE, HOLD, DONE.
REQ-019 SHALL, in IDLE with cyc=1, latch a/we/wdata and go to SETUP; address changes after this latch are ignored for the rest of the cycle.
REQ-020 SHALL, from SETUP (1 cycle, no select asserted), go to STROBE for mapped targets and directly to DONE for unmapped targets.
REQ-021 SHALL, in STROBE, assert exactly one select (rom_cs or cs[idx]) for N+1 cycles, where N=ROM_WS or WS[idx], using a 4-bit down-counter loaded on STROBE entry.
REQ-022 SHALL, from HOLD (1 cycle, all selects low), go to DONE.
REQ-023 SHALL, in DONE, assert ack while cyc=1 and return to IDLE on the first cycle cyc=0; ack SHALL be registered and fall in the cycle after cyc falls.
REQ-024 SHALL, if cyc falls before DONE, complete the sequence with no abort, never assert ack, and leave DONE immediately.
REQ-025 SHALL, for a write (we=1) to idx==FPL_IDX, load rom_page<=wdata on the first STROBE cycle; cs[FPL_IDX] still asserts normally.
REQ-026 SHALL update rom_page only as required by REQ-025.
REQ-027 SHALL drive cs, rom_cs and ack from registers, glitch-free, with at most one select high at any time.
REQ-028 SHALL have latency from the cyc=1 sample to ack high of 4+N cycles when mapped and 2 cycles when unmapped.
REQ-029 SHALL, when a new cyc is seen in IDLE in the same cycle as DONE exits, start that new cycle one clock later, so back-to-back cycles have at least one IDLE cycle between them.

Reset
REQ-030 SHALL, while rst=1 on a rising clock edge, force state=IDLE, cs=0, rom_cs=0, ack=0, busy=0, rom_page=0 and counter=0.
REQ-031 SHALL, on reset during any state including mid-STROBE, drop all selects at that edge with no HOLD and no ack.
REQ-032 SHALL give rst priority over cyc.

Verification
REQ-033 SHALL be verified with: defaults, cyc=1, a=0x0100 (A13=0) -> rom_cs high for 3 cycles starting cycle 2, ack at cycle 6, busy high cycles 1-6.
REQ-034 SHALL be verified with: WS[7:4]=3, a[13:10]=4'b1001 -> cs=7'b0000010 for 4 cycles, ack latency 7.
REQ-035 SHALL be verified with: write idx 4, wdata=0xA5 -> rom_page=0xA5 the cycle after STROBE entry, cs[4] pulsed; a read to idx 4 leaves 0xA5 unchanged.
REQ-036 SHALL be verified with: N_CS=5, a[13:10]=4'b1110 -> no select ever high, ack 2 cycles after cyc.
REQ-037 SHALL be verified with: rst asserted on the 2nd STROBE cycle -> cs=0, ack=0, rom_page=0 next edge; state IDLE.
REQ-038 SHALL be verified with: cyc dropped during SETUP -> full select pulse, ack never high, IDLE one cycle after HOLD.
